fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the single-cycle RV32I core. Owns the PC, fetches instruction words from instruction memory over a req/ready + rvalid handshake, and holds each word in an instruction register.
- The held word drives the immediate extender's DATA input and the decoder.
- Consumes the extender's output (imm) together with rs1 to compute branch, JAL and JALR targets for the next fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, value of instr whenever instr_valid is low (addi x0,x0,0).
- TRAP_VEC, 32'h0000_0100, misaligned-target redirect address (MISALIGN_TRAP_EN only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- instr  out  32  held instruction; goes to the extender's DATA input and the decoder.
- instr_pc  out  32  PC of instr.
- instr_valid  out  1  instr is valid and held.
- instr_ack  in  1  core has executed instr.
- stall  in  1  core not ready; blocks ack.
- pc_src  in  2  next-PC select: 00 = PC+4, 01 = PC+imm (taken branch/JAL), 10 = (rs1+imm)&~1 (JALR), 11 = PC+4.
- imm  in  32  extended immediate from the extender.
- rs1  in  32  register operand for JALR.
- misalign  out  1  one-cycle trap pulse.

Behaviour:
- Reset (sync, highest priority, any state):
  - state=FETCH, pc=RESET_PC, imem_req=0, instr=NOP_INSTR, instr_pc=0, instr_valid=0, misalign=0.
  - The first request is issued the cycle after rst deasserts.
- States: FETCH, WAIT, HOLD.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_ready=1 -> WAIT.
  - req stays high and addr stays stable until ready is seen; no withdrawal.
- WAIT:
  - imem_req=0.
  - imem_rvalid=1 -> instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, go to HOLD.
  - instr_valid rises the cycle after rvalid.
- HOLD:
  - instr, instr_pc and instr_valid stay stable.
  - instr_ack=1 and stall=0 -> compute the next pc, instr_valid<=0, instr<=NOP_INSTR, go to FETCH.
  - instr_ack with stall=1 is ignored.
- instr_ack is ignored outside HOLD.
- imem_rvalid is ignored in FETCH and HOLD. Stale responses after a mid-WAIT reset are dropped because reset returns the block to FETCH.
- Minimum fetch-to-ack period: 3 cycles when memory is zero-wait (ready in FETCH, rvalid in the first WAIT cycle, ack in the first HOLD cycle).
- Next-PC arithmetic:
  - All sums are 32-bit modulo 2^32; carry is dropped.
  - 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - Targets use instr_pc, not pc.
  - JALR clears bit 0 after the add.
- The block does not change pc_src, imm or rs1; they are sampled only in the ack cycle.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: if the computed target[1:0] != 2'b00 in the ack cycle, then:
  - pc <= TRAP_VEC;
  - misalign=1 for exactly that one cycle (registered, visible the cycle after ack);
  - the state machine continues to FETCH normally.
- Undefined:
  - Target bits [1:0] are forced to 2'b00.
  - misalign is tied to 0.
  - TRAP_VEC is unused.

Test Plan:
- Reset, then zero-wait memory returning 32'h0050_0093 -> imem_addr=0 on the first req; instr=32'h0050_0093, instr_pc=0, instr_valid=1 two cycles later; ack with pc_src=00 -> next imem_addr=4.
- Branch: instr_pc=32'h40, pc_src=01, imm=32'hFFFF_FFF0 -> next imem_addr=32'h30. JALR: rs1=32'h1001, imm=4, pc_src=10 -> imem_addr=32'h1004.
- Memory backpressure: imem_ready low for 3 cycles, then rvalid 2 cycles after acceptance -> req/addr held constant for all 3 cycles; exactly one instr capture; instr_valid stays 0 until capture.
- Stall: HOLD with instr_ack=1, stall=1 for 4 cycles -> instr/instr_valid unchanged, no new req; stall drops -> advance the next cycle.
- Wrap and reset: pc=32'hFFFF_FFFC, ack with pc_src=00 -> imem_addr=0. rst in WAIT followed by a late rvalid with 32'hDEAD_BEEF -> instr stays NOP_INSTR, instr_valid=0, fetch restarts at RESET_PC.
- MISALIGN_TRAP_EN defined: instr_pc=8, imm=6, pc_src=01 -> misalign pulses once, next imem_addr=32'h100. Undefined: same stimulus -> imem_addr=32'hC, misalign stays 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the single-cycle RV32I core.
// Owns the PC. Fetches over a req/ready + rvalid handshake and holds each word until the
// core acks it. Computes the next PC from pc_src, imm and rs1.
// Optional build macro MISALIGN_TRAP_EN: a misaligned next-PC target redirects to TRAP_VEC
// and pulses misalign for one cycle. Without the macro, target bits [1:0] are cleared.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
`ifdef MISALIGN_TRAP_EN
    ,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    output logic        misalign
);

    typedef enum logic [1:0] {StFetch, StWait, StHold} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] target;

    assign imem_addr = pc;

    // Next-PC target; offsets are taken from instr_pc, the PC of the held word.
    always_comb begin
        target = instr_pc + 32'd4;
        case (pc_src)
            2'b01:   target = instr_pc + imm;
            2'b10:   target = (rs1 + imm) & 32'hFFFF_FFFE;
            default: target = instr_pc + 32'd4;
        endcase
    end

    // Fetch FSM with registered handshake and instruction outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StFetch;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= NOP_INSTR;
            instr_pc    <= 32'h0000_0000;
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state)
                StFetch: begin
                    // Only after reset is req low here; raise it, then hold until accepted.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ready) begin
                        imem_req <= 1'b0;
                        state    <= StWait;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= StHold;
                    end
                end
                StHold: begin
                    if (instr_ack && !stall) begin
                        instr       <= NOP_INSTR;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= StFetch;
`ifdef MISALIGN_TRAP_EN
                        if (target[1:0] != 2'b00) begin
                            pc       <= TRAP_VEC;
                            misalign <= 1'b1;
                        end else begin
                            pc <= target;
                        end
`else
                        pc <= target & 32'hFFFF_FFFC;
`endif
                    end
                end
                default: state <= StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetch/ack traffic
// against an arithmetic next-PC model. Honours MISALIGN_TRAP_EN like the design.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ack;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .stall       (stall),
        .pc_src      (pc_src),
        .imm         (imm),
        .rs1         (rs1),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

    // Next PC from the ISA rules, using 64-bit arithmetic reduced modulo 2^32.
    function automatic logic [31:0] model_next(input logic [31:0] ipc, input logic [1:0] src,
                                               input logic [31:0] im, input logic [31:0] r1,
                                               output logic trap);
        longint unsigned m, a, b, c, raw;
        m   = 64'h1_0000_0000;
        a   = {32'h0, ipc};
        b   = {32'h0, im};
        c   = {32'h0, r1};
        if (src == 2'd1)      raw = (a + b) % m;
        else if (src == 2'd2) begin
            raw = (c + b) % m;
            raw = raw - (raw % 2);
        end else              raw = (a + 4) % m;
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (raw % 4 != 0) begin
            trap = 1'b1;
            return TRAP_VEC;
        end
`endif
        raw = raw - (raw % 4);
        return raw[31:0];
    endfunction

    // Serve one fetch: ready after rdly cycles, rvalid after vdly WAIT cycles.
    task automatic do_fetch(input logic [31:0] data, input int rdly, input int vdly,
                            input logic ack_noise);
        int n = 0;
        instr_ack  = ack_noise;
        stall      = 1'b0;
        imem_ready = 1'b0;
        while (!imem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (imem_req !== 1'b1) begin
            bad++;
            $display("FAIL fetch_req_timeout: req=%b want 1", imem_req);
        end
        total++;
        if (imem_addr !== exp_pc) begin
            bad++;
            $display("FAIL fetch_addr: got %h want %h", imem_addr, exp_pc);
        end
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            total++;
            if ({imem_req, imem_addr, instr_valid} !== {1'b1, exp_pc, 1'b0}) begin
                bad++;
                $display("FAIL fetch_backpressure: req=%b addr=%h valid=%b want 1 %h 0",
                         imem_req, imem_addr, instr_valid, exp_pc);
            end
        end
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        total++;
        if ({imem_req, instr_valid} !== 2'b00) begin
            bad++;
            $display("FAIL wait_req: req=%b valid=%b want 0 0", imem_req, instr_valid);
        end
        for (int i = 0; i < vdly; i++) begin
            imem_rdata = $urandom;
            @(negedge clk);
            total++;
            if ({imem_req, instr_valid} !== 2'b00) begin
                bad++;
                $display("FAIL wait_idle: req=%b valid=%b want 0 0", imem_req, instr_valid);
            end
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        instr_ack   = 1'b0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        exp_instr   = data;
        total++;
        if ({instr, instr_pc, instr_valid} !== {data, exp_pc, 1'b1}) begin
            bad++;
            $display("FAIL capture: instr=%h pc=%h valid=%b want %h %h 1",
                     instr, instr_pc, instr_valid, data, exp_pc);
        end
    endtask

    // Ack the held word after stalls cycles of ack-with-stall; check redirect and trap pulse.
    task automatic do_ack(input logic [1:0] src, input logic [31:0] im, input logic [31:0] r1,
                          input int stalls);
        logic        trap;
        logic [31:0] nxt;
        nxt = model_next(exp_pc, src, im, r1, trap);
        for (int i = 0; i < stalls; i++) begin
            instr_ack = 1'b1;
            stall     = 1'b1;
            pc_src    = 2'($urandom_range(0, 3));
            imm       = $urandom;
            rs1       = $urandom;
            @(negedge clk);
            total++;
            if ({instr, instr_valid, imem_req} !== {exp_instr, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL stall_hold: instr=%h valid=%b req=%b want %h 1 0",
                         instr, instr_valid, imem_req, exp_instr);
            end
        end
        instr_ack = 1'b1;
        stall     = 1'b0;
        pc_src    = src;
        imm       = im;
        rs1       = r1;
        @(negedge clk);
        instr_ack = 1'b0;
        pc_src    = 2'($urandom_range(0, 3));
        imm       = $urandom;
        rs1       = $urandom;
        total++;
        if ({instr, instr_valid} !== {NOP_INSTR, 1'b0}) begin
            bad++;
            $display("FAIL ack_clear: instr=%h valid=%b want %h 0", instr, instr_valid, NOP_INSTR);
        end
        total++;
        if ({imem_req, imem_addr, misalign} !== {1'b1, nxt, trap}) begin
            bad++;
            $display("FAIL ack_next: req=%b addr=%h misalign=%b want 1 %h %b",
                     imem_req, imem_addr, misalign, nxt, trap);
        end
        @(negedge clk);
        total++;
        if ({imem_req, imem_addr, misalign} !== {1'b1, nxt, 1'b0}) begin
            bad++;
            $display("FAIL ack_settle: req=%b addr=%h misalign=%b want 1 %h 0",
                     imem_req, imem_addr, misalign, nxt);
        end
        exp_pc = nxt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_ready  = 1'($urandom_range(0, 1));
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            instr_ack   = 1'($urandom_range(0, 1));
            @(negedge clk);
            total++;
            if ({imem_req, imem_addr, instr, instr_pc, instr_valid, misalign} !==
                {1'b0, RESET_PC, NOP_INSTR, 32'h0, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL reset_state: req=%b addr=%h instr=%h pc=%h valid=%b mis=%b",
                         imem_req, imem_addr, instr, instr_pc, instr_valid, misalign);
            end
        end
        rst = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; instr_ack = 1'b0;
        exp_pc = RESET_PC;
        @(negedge clk);
        total++;
        if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
            bad++;
            $display("FAIL first_req: req=%b addr=%h want 1 %h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_basic();
        do_fetch(32'h0050_0093, 0, 0, 1'b0);
        do_ack(2'b00, $urandom, $urandom, 0);
        total++;
        if (imem_addr !== 32'h4) begin
            bad++;
            $display("FAIL basic_next: addr=%h want 00000004", imem_addr);
        end
    endtask

    task automatic test_branch();
        do_fetch($urandom, 0, 0, 1'b0);
        do_ack(2'b10, 32'h4, 32'h3C, 0);
        do_fetch($urandom, 0, 0, 1'b0);
        do_ack(2'b01, 32'hFFFF_FFF0, $urandom, 0);
        total++;
        if (imem_addr !== 32'h30) begin
            bad++;
            $display("FAIL branch_back: addr=%h want 00000030", imem_addr);
        end
        do_fetch($urandom, 0, 0, 1'b0);
        do_ack(2'b10, 32'h4, 32'h1001, 0);
        total++;
        if (imem_addr !== 32'h1004) begin
            bad++;
            $display("FAIL jalr_target: addr=%h want 00001004", imem_addr);
        end
        do_fetch($urandom, 0, 0, 1'b0);
        do_ack(2'b11, $urandom, $urandom, 0);
    endtask

    task automatic test_backpressure();
        do_fetch($urandom, 3, 2, 1'b1);
        imem_rvalid = 1'b1;
        imem_rdata  = ~exp_instr;
        @(negedge clk);
        imem_rvalid = 1'b0;
        total++;
        if ({instr, instr_valid} !== {exp_instr, 1'b1}) begin
            bad++;
            $display("FAIL single_capture: instr=%h valid=%b want %h 1",
                     instr, instr_valid, exp_instr);
        end
        do_ack(2'b00, $urandom, $urandom, 0);
    endtask

    task automatic test_stall();
        do_fetch($urandom, 0, 0, 1'b0);
        do_ack(2'b00, $urandom, $urandom, 4);
    endtask

    task automatic test_wrap();
        do_fetch($urandom, 0, 0, 1'b0);
        do_ack(2'b10, 32'h0, 32'hFFFF_FFFC, 0);
        do_fetch($urandom, 1, 0, 1'b0);
        do_ack(2'b00, $urandom, $urandom, 0);
        total++;
        if (imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL wrap: addr=%h want 00000000", imem_addr);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] want;
`ifdef MISALIGN_TRAP_EN
        want = TRAP_VEC;
`else
        want = 32'hC;
`endif
        do_fetch($urandom, 0, 0, 1'b0);
        do_ack(2'b10, 32'h0, 32'h8, 0);
        do_fetch($urandom, 0, 0, 1'b0);
        do_ack(2'b01, 32'h6, $urandom, 0);
        total++;
        if (imem_addr !== want) begin
            bad++;
            $display("FAIL misalign_target: addr=%h want %h", imem_addr, want);
        end
    endtask

    task automatic test_reset_mid_wait();
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        exp_pc      = RESET_PC;
        total++;
        if ({instr, instr_valid, imem_req, imem_addr} !== {NOP_INSTR, 1'b0, 1'b1, RESET_PC}) begin
            bad++;
            $display("FAIL stale_rvalid: instr=%h valid=%b req=%b addr=%h want %h 0 1 %h",
                     instr, instr_valid, imem_req, imem_addr, NOP_INSTR, RESET_PC);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_fetch($urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)));
            do_ack(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 2));
        end
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        instr_ack = 1'b0; stall = 1'b0; pc_src = 2'b00; imm = 32'h0; rs1 = 32'h0;
        exp_pc = RESET_PC; exp_instr = NOP_INSTR;
        test_reset();
        test_basic();
        test_branch();
        test_backpressure();
        test_stall();
        test_wrap();
        test_misalign();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
